hazard_ctrl: RTL and testbench

- Issue controller for the decode stage. Consumes the decoded instruction class (load, store, branch, undefined) and register fields, and decides each cycle whether the instruction in ID may issue to EX.
- Keeps a per-register scoreboard of outstanding load destinations, a bounded outstanding-load counter and a branch-resolution state machine.
- Drives the decode-stage stall, the fetch flush and the undefined-instruction trap.

---
 rtl/hazard_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Issue controller for the decode stage. Each cycle it decides whether the
//   instruction in ID may move to EX. It tracks:
//     * a per-register scoreboard of outstanding load destinations
//       (r0 is never tracked), bypassed by a same-cycle load writeback,
//     * a bounded outstanding-load counter (at most MAX_LD loads in flight),
//     * a branch-resolution state machine (RUN / BR_WAIT / FLUSH / TRAP).
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous, active-low reset
//   id_valid_i    ID holds a valid decoded instruction
//   id_rs1_i      source register 1
//   id_rs2_i      source register 2
//   id_rd_i       destination register
//   id_use_rs1_i  instruction reads rs1
//   id_use_rs2_i  instruction reads rs2
//   id_wr_i       instruction writes rd
//   id_ld_i       load class
//   id_br_i       branch class
//   id_und_i      undefined opcode
//   ex_ready_i    EX can accept an instruction this cycle
//   wb_valid_i    load writeback completes this cycle
//   wb_rd_i       load writeback destination
//   br_resolve_i  EX resolves the outstanding branch
//   br_taken_i    resolved branch is taken (qualified by br_resolve_i)
//   issue_o       instruction in ID issues this cycle (combinational)
//   stall_o       hold ID/IF registers (combinational)
//   flush_o       squash IF/ID contents, one-cycle pulse (registered)
//   trap_o        undefined-instruction trap, sticky until reset (registered)
//   ld_cnt_o      outstanding load count
//   err_o         one-cycle pulse: writeback to r0 or a non-pending register
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int N_REG  = 32,
    parameter int W_RADR = 5,
    parameter int MAX_LD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [W_RADR-1:0] id_rs1_i,
    input  logic [W_RADR-1:0] id_rs2_i,
    input  logic [W_RADR-1:0] id_rd_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_wr_i,
    input  logic              id_ld_i,
    input  logic              id_br_i,
    input  logic              id_und_i,
    input  logic              ex_ready_i,
    input  logic              wb_valid_i,
    input  logic [W_RADR-1:0] wb_rd_i,
    input  logic              br_resolve_i,
    input  logic              br_taken_i,
    output logic              issue_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              trap_o,
    output logic [2:0]        ld_cnt_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_BR_WAIT = 2'd1,
        S_FLUSH   = 2'd2,
        S_TRAP    = 2'd3
    } state_t;

    state_t            state;
    logic              flush_q;
    logic              trap_q;
    logic [N_REG-1:0]  sb;
    logic [2:0]        ld_cnt;

    logic [N_REG-1:0]  wb_vec;
    logic [N_REG-1:0]  ld_vec;
    logic [N_REG-1:0]  sb_eff;
    logic              wb_clear;
    logic [2:0]        ld_cnt_eff;
    logic              ld_full;
    logic              hazard;
    logic              in_run;
    logic              und_take;
    logic              ld_track;

    // One-hot of the register a writeback targets; r0 never appears here.
    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        wb_vec = '0;
        if (wb_valid_i && (wb_rd_i != '0)) wb_vec[wb_rd_i] = 1'b1;
    end

    // A writeback only counts when it retires a register that is actually pending.
    assign wb_clear = |(sb & wb_vec);
    assign sb_eff   = sb & ~wb_vec;

    // The last term is the WAW check: a new writer must not race an older load.
    assign hazard = (id_use_rs1_i && (id_rs1_i != '0) && sb_eff[id_rs1_i])
                  | (id_use_rs2_i && (id_rs2_i != '0) && sb_eff[id_rs2_i])
                  | (id_wr_i      && (id_rd_i  != '0) && sb_eff[id_rd_i]);

    // A retiring load frees its slot in the same cycle, so a full window can still accept.
    assign ld_cnt_eff = ld_cnt - {2'b00, wb_clear};
    assign ld_full    = (ld_cnt_eff == 3'(MAX_LD));

    assign in_run   = (state == S_RUN);
    assign und_take = in_run && id_valid_i && id_und_i;

    // Combinational outputs are forced low while reset is held so that the
    // whole block looks idle asynchronously, not just after the next edge.
    assign issue_o = rst && id_valid_i && ex_ready_i && in_run && !id_und_i
                  && !hazard && !(id_ld_i && ld_full);

    // No stall while trapping, flushing, or on the cycle an undefined opcode is taken.
    assign stall_o = rst && id_valid_i && !issue_o && (state != S_TRAP)
                  && (state != S_FLUSH) && !und_take;

    assign err_o = rst && wb_valid_i && !wb_clear;

    // Loads to r0 issue but are not tracked.
    assign ld_track = issue_o && id_ld_i && (id_rd_i != '0);

    always_comb begin
        ld_vec = '0;
        if (ld_track) ld_vec[id_rd_i] = 1'b1;
    end

    // Scoreboard and load counter keep updating in every state, including TRAP.
    // Set after clear: a load reissuing to the register being written back keeps the bit.
    // NOTE: the scoreboard is a register bank that must read as empty out of reset, so every bit is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb     <= '0;
            ld_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            sb     <= (sb & ~wb_vec) | ld_vec;
            ld_cnt <= ld_cnt_eff + {2'b00, ld_track};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_RUN;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                S_RUN: begin
                    if (und_take) begin
                        state  <= S_TRAP;
                        trap_q <= 1'b1;
                    end else if (issue_o && id_br_i) begin
                        state <= S_BR_WAIT;
                    end
                end
                S_BR_WAIT: begin
                    if (br_resolve_i) begin
                        if (br_taken_i) begin
                            state   <= S_FLUSH;
                            flush_q <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_FLUSH: state <= S_RUN;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_RUN;
            endcase
        end
    end

    assign flush_o  = flush_q;
    assign trap_o   = trap_q;
    assign ld_cnt_o = ld_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Purpose:
//   Directed, self-checking bench for hazard_ctrl. Inputs change 1 time unit
//   after the rising edge; outputs are compared a further 1 unit later, well
//   away from the next edge. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid, use1, use2, wr, ld, br, und;
    logic [4:0] rs1, rs2, rd, wb_rd;
    logic       ex_ready, wb_valid, br_resolve, br_taken;
    logic       issue, stall, flush, trap, err;
    logic [2:0] ld_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.N_REG(32), .W_RADR(5), .MAX_LD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid_i   (id_valid),
        .id_rs1_i     (rs1),
        .id_rs2_i     (rs2),
        .id_rd_i      (rd),
        .id_use_rs1_i (use1),
        .id_use_rs2_i (use2),
        .id_wr_i      (wr),
        .id_ld_i      (ld),
        .id_br_i      (br),
        .id_und_i     (und),
        .ex_ready_i   (ex_ready),
        .wb_valid_i   (wb_valid),
        .wb_rd_i      (wb_rd),
        .br_resolve_i (br_resolve),
        .br_taken_i   (br_taken),
        .issue_o      (issue),
        .stall_o      (stall),
        .flush_o      (flush),
        .trap_o       (trap),
        .ld_cnt_o     (ld_cnt),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever wedges.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 1'b0; use1 = 1'b0; use2 = 1'b0; wr = 1'b0;
        ld = 1'b0; br = 1'b0; und = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0;
    endtask

    task automatic idle();
        clear_id();
        ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0;
        br_resolve = 1'b0; br_taken = 1'b0;
    endtask

    task automatic put_ld(input logic [4:0] d);
        clear_id();
        id_valid = 1'b1; ld = 1'b1; wr = 1'b1; rd = d; use1 = 1'b1; rs1 = '0;
    endtask

    task automatic put_alu(input logic [4:0] s, input logic [4:0] d);
        clear_id();
        id_valid = 1'b1; use1 = 1'b1; rs1 = s; wr = 1'b1; rd = d;
    endtask

    task automatic put_br(input logic [4:0] s);
        clear_id();
        id_valid = 1'b1; br = 1'b1; use1 = 1'b1; rs1 = s;
    endtask

    task automatic put_und();
        clear_id();
        id_valid = 1'b1; und = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        put_alu(5'd1, 5'd2);
        #3;
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL rst_issue: got %b want 0", issue); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", flush); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL rst_trap: got %b want 0", trap); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (ld_cnt !== 3'd0) begin errors++; $display("FAIL rst_ld_cnt: got %0d want 0", ld_cnt); end
        @(negedge clk);
        rst = 1'b1;
        idle();
        cyc();
    endtask

    task automatic test_load_use();
        put_ld(5'd5);
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL lu_c0_issue: got %b want 1", issue); end
        cyc();
        put_alu(5'd5, 5'd8);
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL lu_c1: issue=%b stall=%b want issue=0 stall=1", issue, stall); end
        checks++; if (ld_cnt !== 3'd1) begin errors++; $display("FAIL lu_c1_ld_cnt: got %0d want 1", ld_cnt); end
        cyc();
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL lu_c2: issue=%b stall=%b want issue=0 stall=1", issue, stall); end
        cyc();
        wb_valid = 1'b1; wb_rd = 5'd5;
        #1;
        checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL lu_c3_bypass: issue=%b stall=%b want issue=1 stall=0", issue, stall); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lu_c3_err: got %b want 0", err); end
        cyc();
        idle();
        #1;
        checks++; if (ld_cnt !== 3'd0) begin errors++; $display("FAIL lu_c4_ld_cnt: got %0d want 0", ld_cnt); end
    endtask

    task automatic test_waw();
        put_ld(5'd9);
        cyc();
        put_ld(5'd9);
        #1;
        checks++; if (issue !== 1'b0) begin errors++; $display("FAIL waw_block: got %b want 0", issue); end
        cyc();
        wb_valid = 1'b1; wb_rd = 5'd9;
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_bypass_issue: got %b want 1", issue); end
        cyc();
        idle();
        #1;
        checks++; if (ld_cnt !== 3'd1) begin errors++; $display("FAIL waw_same_rd_cnt: got %0d want 1", ld_cnt); end
        wb_valid = 1'b1; wb_rd = 5'd9;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL waw_bit_kept: err=%b want 0", err); end
        cyc();
        idle();
        #1;
        checks++; if (ld_cnt !== 3'd0) begin errors++; $display("FAIL waw_drain_cnt: got %0d want 0", ld_cnt); end
    endtask

    task automatic test_ld_full();
        for (int i = 1; i <= 4; i++) begin
            put_ld(5'(i));
            #1;
            checks++; if (issue !== 1'b1) begin errors++; $display("FAIL full_ld%0d_issue: got %b want 1", i, issue); end
            cyc();
        end
        put_ld(5'd6);
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL full_5th: issue=%b stall=%b want issue=0 stall=1", issue, stall); end
        checks++; if (ld_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt4: got %0d want 4", ld_cnt); end
        cyc();
        wb_valid = 1'b1; wb_rd = 5'd2;
        #1;
        checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL full_wb_frees: issue=%b stall=%b want issue=1 stall=0", issue, stall); end
        cyc();
        idle();
        #1;
        checks++; if (ld_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt_stays4: got %0d want 4", ld_cnt); end
        for (int r = 1; r <= 6; r++) begin
            if (r != 2 && r != 5) begin
                wb_valid = 1'b1; wb_rd = 5'(r);
                cyc();
            end
        end
        idle();
        #1;
        checks++; if (ld_cnt !== 3'd0) begin errors++; $display("FAIL full_drain_cnt: got %0d want 0", ld_cnt); end
    endtask

    task automatic test_err();
        wb_valid = 1'b1; wb_rd = 5'd7;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_r7: got %b want 1", err); end
        cyc();
        idle();
        #1;
        checks++; if (err !== 1'b0 || ld_cnt !== 3'd0) begin errors++; $display("FAIL err_r7_after: err=%b ld_cnt=%0d want 0/0", err, ld_cnt); end
        wb_valid = 1'b1; wb_rd = 5'd0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_r0: got %b want 1", err); end
        cyc();
        idle();
        put_ld(5'd0);
        #1;
        checks++; if (issue !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL ld_r0_issue: issue=%b err=%b want 1/0", issue, err); end
        cyc();
        idle();
        #1;
        checks++; if (ld_cnt !== 3'd0) begin errors++; $display("FAIL ld_r0_cnt: got %0d want 0", ld_cnt); end
    endtask

    task automatic test_branch_taken();
        br_resolve = 1'b1; br_taken = 1'b1;
        cyc();
        idle();
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL br_ignored_in_run: flush=%b want 0", flush); end
        put_br(5'd1);
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL brt_issue: got %b want 1", issue); end
        cyc();
        put_alu(5'd0, 5'd11);
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL brt_wait1: issue=%b stall=%b flush=%b want 0/1/0", issue, stall, flush); end
        cyc();
        br_resolve = 1'b1; br_taken = 1'b1;
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL brt_wait2: issue=%b stall=%b want 0/1", issue, stall); end
        cyc();
        br_resolve = 1'b0; br_taken = 1'b0;
        #1;
        checks++; if (flush !== 1'b1 || issue !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL brt_flush: flush=%b issue=%b stall=%b want 1/0/0", flush, issue, stall); end
        cyc();
        checks++; if (flush !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL brt_resume: flush=%b issue=%b want 0/1", flush, issue); end
        cyc();
        idle();
    endtask

    task automatic test_branch_not_taken();
        put_br(5'd2);
        cyc();
        put_alu(5'd0, 5'd12);
        br_resolve = 1'b1; br_taken = 1'b0;
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL brn_wait: issue=%b stall=%b want 0/1", issue, stall); end
        cyc();
        br_resolve = 1'b0;
        #1;
        checks++; if (issue !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL brn_resume: issue=%b flush=%b want 1/0", issue, flush); end
        cyc();
        idle();
    endtask

    task automatic test_und_in_brwait();
        put_br(5'd0);
        cyc();
        put_und();
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL und_brw_stall: issue=%b stall=%b want 0/1", issue, stall); end
        br_resolve = 1'b1; br_taken = 1'b1;
        cyc();
        idle();
        #1;
        checks++; if (flush !== 1'b1 || trap !== 1'b0) begin errors++; $display("FAIL und_brw_flushed: flush=%b trap=%b want 1/0", flush, trap); end
        cyc();
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL und_brw_no_trap: trap=%b want 0", trap); end
    endtask

    task automatic test_trap();
        put_ld(5'd10);
        cyc();
        put_und();
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b0 || trap !== 1'b0) begin errors++; $display("FAIL trap_take: issue=%b stall=%b trap=%b want 0/0/0", issue, stall, trap); end
        cyc();
        put_alu(5'd0, 5'd13);
        #1;
        checks++; if (trap !== 1'b1 || issue !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL trap_on: trap=%b issue=%b stall=%b want 1/0/0", trap, issue, stall); end
        wb_valid = 1'b1; wb_rd = 5'd10;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL trap_wb_err: got %b want 0", err); end
        cyc();
        wb_valid = 1'b0;
        #1;
        checks++; if (ld_cnt !== 3'd0) begin errors++; $display("FAIL trap_wb_clears: ld_cnt=%0d want 0", ld_cnt); end
        cyc();
        checks++; if (trap !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL trap_sticky: trap=%b issue=%b want 1/0", trap, issue); end
        rst = 1'b0;
        #1;
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL trap_rst_clear: trap=%b want 0", trap); end
        @(negedge clk);
        rst = 1'b1;
        idle();
        cyc();
    endtask

    task automatic test_reset_mid();
        put_ld(5'd3);
        cyc();
        put_br(5'd0);
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL rm_br_issue: got %b want 1", issue); end
        cyc();
        put_alu(5'd3, 5'd14);
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b1 || ld_cnt !== 3'd1) begin errors++; $display("FAIL rm_pre: issue=%b stall=%b ld_cnt=%0d want 0/1/1", issue, stall, ld_cnt); end
        rst = 1'b0;
        #1;
        checks++; if (issue !== 1'b0 || stall !== 1'b0 || flush !== 1'b0 || trap !== 1'b0 || err !== 1'b0 || ld_cnt !== 3'd0)
            begin errors++; $display("FAIL rm_async: issue=%b stall=%b flush=%b trap=%b err=%b ld_cnt=%0d want all 0", issue, stall, flush, trap, err, ld_cnt); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rm_release_issue: issue=%b stall=%b want 1/0", issue, stall); end
        cyc();
        idle();
        #1;
        checks++; if (ld_cnt !== 3'd0) begin errors++; $display("FAIL rm_final_cnt: got %0d want 0", ld_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_waw();
        test_ld_full();
        test_err();
        test_branch_taken();
        test_branch_not_taken();
        test_und_in_brwait();
        test_trap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
